// File: rtl/showcase_table_writer.sv
// Burst writer for a small synchronous lookup table: accepts a valid/ready word stream
// and writes it from a base address with wrap-around; exposes a 1-cycle registered read port.
module showcase_table_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_vld,
  output logic                  din_rd,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wr_cnt,
  output logic                  err,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;
  logic [ADDR_WIDTH:0]   rem_q;
  logic [ADDR_WIDTH:0]   rem_d;
  logic [ADDR_WIDTH:0]   wr_cnt_q;
  logic [ADDR_WIDTH:0]   wr_cnt_d;
  logic                  din_rd_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  beat_s;

  // Table contents survive rst; only power-up clears them.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  assign beat_s   = din_rd_q & din_vld & ~rst;
  assign ptr_d    = ptr_q + PTR_ONE;
  assign rem_d    = rem_q - CNT_ONE;
  assign wr_cnt_d = wr_cnt_q + CNT_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      wr_cnt_q <= '0;
      din_rd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            wr_cnt_q <= '0;
            busy_q   <= 1'b1;
            if (len != '0) begin
              state_q  <= LOAD;
              ptr_q    <= base;
              rem_q    <= len;
              din_rd_q <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (start) begin
            err_q <= 1'b1;
          end
          if (beat_s) begin
            ptr_q    <= ptr_d;
            rem_q    <= rem_d;
            wr_cnt_q <= wr_cnt_d;
            if (rem_q == CNT_ONE) begin
              state_q  <= DONE;
              din_rd_q <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            err_q <= 1'b1;
          end
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          din_rd_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (beat_s) begin
      mem_q[ptr_q] <= din;
    end
  end

  // Non-blocking read against the same array gives read-before-write on address collisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign din_rd  = din_rd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_cnt  = wr_cnt_q;
  assign err     = err_q;
  assign rd_data = rd_data_q;

endmodule
